// File: rtl/multi_receiver_collector.sv
// multi_receiver_collector
//
// Purpose:
//   Merges decoded sweep words from NUM_RECV receiver managers into one
//   ordered, channel-tagged stream. Each channel has a one-deep pending slot.
//   A round-robin arbiter moves at most one slot per cycle into a
//   first-word-fall-through FIFO, which the consumer drains over a
//   valid/ready handshake. The block also owns the free-running system
//   timestamp that every receiver manager stamps its events with.
//
// Ports:
//   clk_96MHz        system clock from the PLL
//   reset            asynchronous, active-high reset
//   system_timestamp free-running TS_W-bit counter, fanned out to receivers
//   chan_valid       one-cycle data-available pulse per channel
//   chan_data        decoded words, channel i at [i*DATA_W +: DATA_W]
//   chan_timestamp   event timestamps, channel i at [i*TS_W +: TS_W]
//   out_valid        FIFO head is valid
//   out_ready        consumer accepts the head this cycle
//   out_data         head data word
//   out_timestamp    head timestamp
//   out_channel      head source channel
//   fifo_level       current FIFO occupancy
//   drop_flags       sticky per-channel drop indicator
//   drop_count       saturating total of dropped events
//
// Build option:
//   DROP_COUNT_EN    when defined, the saturating drop counter is built.
//                    Otherwise drop_count is tied to 0 (drop_flags still work).

module multi_receiver_collector #(
    parameter  int NUM_RECV   = 4,
    parameter  int DATA_W     = 17,
    parameter  int TS_W       = 24,
    parameter  int FIFO_DEPTH = 16,
    localparam int CH_W       = (NUM_RECV > 1) ? $clog2(NUM_RECV) : 1,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                       clk_96MHz,
    input  logic                       reset,
    output logic [TS_W-1:0]            system_timestamp,
    input  logic [NUM_RECV-1:0]        chan_valid,
    input  logic [NUM_RECV*DATA_W-1:0] chan_data,
    input  logic [NUM_RECV*TS_W-1:0]   chan_timestamp,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [TS_W-1:0]            out_timestamp,
    output logic [CH_W-1:0]            out_channel,
    output logic [LVL_W-1:0]           fifo_level,
    output logic [NUM_RECV-1:0]        drop_flags,
    output logic [7:0]                 drop_count
);

    localparam int                AW         = $clog2(FIFO_DEPTH);
    localparam int                ENTRY_W    = CH_W + TS_W + DATA_W;
    localparam logic [CH_W:0]     NUM_RECV_C = (CH_W + 1)'(NUM_RECV);
    localparam logic [LVL_W-1:0]  DEPTH_C    = LVL_W'(FIFO_DEPTH);

    logic [TS_W-1:0]     ts_q;
    logic [NUM_RECV-1:0] pend_valid;
    logic [DATA_W-1:0]   pend_data [NUM_RECV];
    logic [TS_W-1:0]     pend_ts   [NUM_RECV];
    logic [CH_W-1:0]     rr_ptr;

    logic                grant_any;
    logic                grant;
    logic [CH_W-1:0]     grant_idx;
    logic [CH_W:0]       scan;
    logic [NUM_RECV-1:0] grant_vec;
    logic [NUM_RECV-1:0] load_vec;
    logic [NUM_RECV-1:0] drop_now;

    logic [LVL_W-1:0]    level;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       rd_next;
    logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];
    logic [ENTRY_W-1:0]  head_q;
    logic [ENTRY_W-1:0]  push_entry;
    logic                pop;
    logic                can_accept;

    // Free-running timestamp; natural binary wrap to zero.
    always_ff @(posedge clk_96MHz or posedge reset) begin
        if (reset) ts_q <= '0;
        else       ts_q <= ts_q + TS_W'(1);
    end

    assign system_timestamp = ts_q;

    // Round-robin search: walk the channels from the pointer downwards in
    // reverse so the candidate closest to the pointer is the last one written
    // and therefore wins. rr_ptr + k never exceeds 2*NUM_RECV-2, so a single
    // conditional subtraction is enough for the modulo.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan      = '0;
        for (int k = NUM_RECV - 1; k >= 0; k--) begin
            scan = {1'b0, rr_ptr} + (CH_W + 1)'(k);
            if (scan >= NUM_RECV_C) scan = scan - NUM_RECV_C;
            if (pend_valid[scan[CH_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = scan[CH_W-1:0];
            end
        end
    end

    assign pop        = out_valid & out_ready;
    assign can_accept = (level < DEPTH_C) | pop;
    assign grant      = grant_any & can_accept;
    assign push_entry = {grant_idx, pend_ts[grant_idx], pend_data[grant_idx]};

    // A slot that is granted this cycle counts as free, so a new event on
    // the same channel loads instead of being dropped.
    always_comb begin
        grant_vec = '0;
        if (grant) grant_vec[grant_idx] = 1'b1;
    end

    assign load_vec = chan_valid & ~(pend_valid & ~grant_vec);
    assign drop_now = chan_valid &   pend_valid & ~grant_vec;

    // Slot occupancy, sticky drop flags and the arbiter pointer.
    always_ff @(posedge clk_96MHz or posedge reset) begin
        if (reset) begin
            pend_valid <= '0;
            drop_flags <= '0;
            rr_ptr     <= '0;
        end else begin
            pend_valid <= (pend_valid & ~grant_vec) | chan_valid;
            drop_flags <= drop_flags | drop_now;
            if (grant) begin
                rr_ptr <= (grant_idx == CH_W'(NUM_RECV - 1)) ? '0
                                                             : grant_idx + CH_W'(1);
            end
        end
    end

    // Slot payloads need no reset: they are only read while the slot is pending.
    always_ff @(posedge clk_96MHz) begin
        for (int i = 0; i < NUM_RECV; i++) begin
            if (load_vec[i]) begin
                pend_data[i] <= chan_data[i*DATA_W +: DATA_W];
                pend_ts[i]   <= chan_timestamp[i*TS_W +: TS_W];
            end
        end
    end

    // FIFO storage; a push while full is only possible together with a pop,
    // and the entry being overwritten has already been copied to head_q.
    always_ff @(posedge clk_96MHz) begin
        if (grant) mem[wr_ptr] <= push_entry;
    end

    assign rd_next = rd_ptr + AW'(1);

    // FIFO pointers, level and the registered head. The head is reloaded
    // from the next stored entry on a pop, or from the incoming entry when it
    // becomes the new head; emptying the FIFO leaves the last head in place.
    always_ff @(posedge clk_96MHz or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            head_q <= '0;
        end else begin
            if (grant) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_next;
            case ({grant, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (pop && (level > LVL_W'(1))) begin
                head_q <= mem[rd_next];
            end else if (grant && ((level == '0) || pop)) begin
                head_q <= push_entry;
            end
        end
    end

    assign out_valid  = (level != '0);
    assign fifo_level = level;
    assign {out_channel, out_timestamp, out_data} = head_q;

`ifdef DROP_COUNT_EN
    logic [7:0] drop_cnt_q;
    logic [8:0] drop_sum;

    // Several channels can drop in one cycle; add them all, then saturate.
    always_comb begin
        drop_sum = {1'b0, drop_cnt_q};
        for (int i = 0; i < NUM_RECV; i++) begin
            drop_sum = drop_sum + 9'(drop_now[i]);
        end
    end

    always_ff @(posedge clk_96MHz or posedge reset) begin
        if (reset)                  drop_cnt_q <= '0;
        else if (drop_sum > 9'd255) drop_cnt_q <= 8'hFF;
        else                        drop_cnt_q <= drop_sum[7:0];
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = 8'h00;
`endif

endmodule

// File: tb/tb_multi_receiver_collector.sv
// tb_multi_receiver_collector
//
// Purpose:
//   Self-checking bench for multi_receiver_collector. A queue-based
//   reference model tracks pending slots, the round-robin pointer, the
//   output stream and drop bookkeeping. It is compared against the DUT on
//   every falling edge. Directed scenarios add literal expectations that pin
//   the model. A second, narrow instance (TS_W=8) exercises timestamp wrap.
//
// Ports: none (top-level bench).

module tb_multi_receiver_collector;

    localparam int NR = 4;
    localparam int DW = 17;
    localparam int TW = 24;
    localparam int FD = 16;

`ifdef DROP_COUNT_EN
    localparam logic [7:0] EXP_ONE_DROP = 8'd1;
`else
    localparam logic [7:0] EXP_ONE_DROP = 8'd0;
`endif

    logic              clk_96MHz = 1'b0;
    logic              reset;
    logic [NR-1:0]     chan_valid;
    logic [NR*DW-1:0]  chan_data;
    logic [NR*TW-1:0]  chan_timestamp;
    logic              out_ready;
    logic [TW-1:0]     system_timestamp;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [TW-1:0]     out_timestamp;
    logic [1:0]        out_channel;
    logic [4:0]        fifo_level;
    logic [NR-1:0]     drop_flags;
    logic [7:0]        drop_count;

    logic [7:0]        w_ts;
    logic              w_out_valid;
    logic [DW-1:0]     w_out_data;
    logic [7:0]        w_out_timestamp;
    logic [0:0]        w_out_channel;
    logic [1:0]        w_fifo_level;
    logic [0:0]        w_drop_flags;
    logic [7:0]        w_drop_count;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk_96MHz = ~clk_96MHz;

    multi_receiver_collector #(
        .NUM_RECV(NR), .DATA_W(DW), .TS_W(TW), .FIFO_DEPTH(FD)
    ) dut (
        .clk_96MHz(clk_96MHz),
        .reset(reset),
        .system_timestamp(system_timestamp),
        .chan_valid(chan_valid),
        .chan_data(chan_data),
        .chan_timestamp(chan_timestamp),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_timestamp(out_timestamp),
        .out_channel(out_channel),
        .fifo_level(fifo_level),
        .drop_flags(drop_flags),
        .drop_count(drop_count)
    );

    multi_receiver_collector #(
        .NUM_RECV(1), .DATA_W(DW), .TS_W(8), .FIFO_DEPTH(2)
    ) dut_wrap (
        .clk_96MHz(clk_96MHz),
        .reset(reset),
        .system_timestamp(w_ts),
        .chan_valid(1'b0),
        .chan_data(17'h0),
        .chan_timestamp(8'h0),
        .out_valid(w_out_valid),
        .out_ready(1'b0),
        .out_data(w_out_data),
        .out_timestamp(w_out_timestamp),
        .out_channel(w_out_channel),
        .fifo_level(w_fifo_level),
        .drop_flags(w_drop_flags),
        .drop_count(w_drop_count)
    );

    // Reference model state
    typedef struct packed {
        logic [1:0]    ch;
        logic [TW-1:0] ts;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        m_fifo[$];
    entry_t        m_head;
    bit            m_pend [NR];
    logic [DW-1:0] m_pdata [NR];
    logic [TW-1:0] m_pts [NR];
    int            m_ptr;
    logic [NR-1:0] m_flags;
    int            m_drops;
    logic [TW-1:0] m_ts;

    logic [1:0]    exp_ch [5];
    logic [DW-1:0] exp_dat [5];

    function automatic void checkOutput(input string name, input logic [31:0] actual,
                                        input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endfunction

    // One clock of the reference: the consumer takes the head, the first
    // pending channel from the pointer enters the stream if there is room,
    // then new events fill free slots or are counted as drops.
    task automatic modelStep();
        bit     pop;
        bit     room;
        int     g;
        int     c;
        entry_t e;
        pop  = (m_fifo.size() != 0) && out_ready;
        room = (m_fifo.size() < FD) || pop;
        g    = -1;
        if (room) begin
            for (int k = 0; k < NR; k++) begin
                c = (m_ptr + k) % NR;
                if (g < 0 && m_pend[c]) g = c;
            end
        end
        if (pop) m_fifo.delete(0);
        if (g >= 0) begin
            e.ch   = 2'(g);
            e.ts   = m_pts[g];
            e.data = m_pdata[g];
            m_fifo.push_back(e);
            m_pend[g] = 0;
            m_ptr     = (g + 1) % NR;
        end
        for (int i = 0; i < NR; i++) begin
            if (chan_valid[i]) begin
                if (m_pend[i]) begin
                    m_flags[i] = 1'b1;
                    if (m_drops < 255) m_drops++;
                end else begin
                    m_pend[i]  = 1;
                    m_pdata[i] = chan_data[i*DW +: DW];
                    m_pts[i]   = chan_timestamp[i*TW +: TW];
                end
            end
        end
        if (m_fifo.size() != 0) m_head = m_fifo[0];
        m_ts = m_ts + 24'd1;
    endtask

    // Model advances on the same edges as the DUT, including async reset.
    always @(posedge clk_96MHz or posedge reset) begin
        if (reset) begin
            m_fifo.delete();
            m_head  = '0;
            for (int i = 0; i < NR; i++) m_pend[i] = 0;
            m_ptr   = 0;
            m_flags = '0;
            m_drops = 0;
            m_ts    = '0;
        end else begin
            modelStep();
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk_96MHz) begin
        checkOutput("out_valid", 32'(out_valid), 32'(m_fifo.size() != 0));
        checkOutput("fifo_level", 32'(fifo_level), 32'(m_fifo.size()));
        checkOutput("out_channel", 32'(out_channel), 32'(m_head.ch));
        checkOutput("out_data", 32'(out_data), 32'(m_head.data));
        checkOutput("out_timestamp", 32'(out_timestamp), 32'(m_head.ts));
        checkOutput("drop_flags", 32'(drop_flags), 32'(m_flags));
`ifdef DROP_COUNT_EN
        checkOutput("drop_count", 32'(drop_count), 32'(m_drops));
`else
        checkOutput("drop_count", 32'(drop_count), 32'h0);
`endif
        checkOutput("system_timestamp", 32'(system_timestamp), 32'(m_ts));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_96MHz);
        #1;
    endtask

    task automatic setChannel(input int ch, input logic [DW-1:0] d, input logic [TW-1:0] t);
        chan_valid[ch]             = 1'b1;
        chan_data[ch*DW +: DW]     = d;
        chan_timestamp[ch*TW +: TW] = t;
    endtask

    // Presents whatever setChannel prepared for exactly one rising edge.
    task automatic applyStimulus();
        @(posedge clk_96MHz);
        #1;
        chan_valid = '0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(posedge clk_96MHz);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_ch  = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd3};
        exp_dat = '{17'h00A00, 17'h00B11, 17'h00D33, 17'h00E00, 17'h00F33};

        reset          = 1'b1;
        chan_valid     = '0;
        chan_data      = '0;
        chan_timestamp = '0;
        out_ready      = 1'b0;

        // Reset state
        tick(1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_fifo_level", 32'(fifo_level), 32'h0);
        checkOutput("rst_ts", 32'(system_timestamp), 32'h0);
        checkOutput("rst_drop_flags", 32'(drop_flags), 32'h0);
        checkOutput("rst_drop_count", 32'(drop_count), 32'h0);
        checkOutput("rst_out_data", 32'(out_data), 32'h0);
        reset = 1'b0;
        tick(3);
        checkOutput("ts_after_3", 32'(system_timestamp), 32'h3);

        // Single event on channel 2, two-cycle latency, then popped
        out_ready = 1'b1;
        setChannel(2, 17'h1ABCD, 24'h000123);
        applyStimulus();
        checkOutput("t1_not_yet_valid", 32'(out_valid), 32'h0);
        tick(1);
        checkOutput("t1_out_valid", 32'(out_valid), 32'h1);
        checkOutput("t1_out_channel", 32'(out_channel), 32'h2);
        checkOutput("t1_out_data", 32'(out_data), 32'h1ABCD);
        checkOutput("t1_out_ts", 32'(out_timestamp), 32'h000123);
        tick(1);
        checkOutput("t1_level_after_pop", 32'(fifo_level), 32'h0);
        checkOutput("t1_head_held", 32'(out_data), 32'h1ABCD);

        // Back-to-back events on one channel: the second arrives while the
        // first is granted, so it must load rather than drop
        setChannel(1, 17'h00111, 24'h000200);
        applyStimulus();
        setChannel(1, 17'h00222, 24'h000201);
        applyStimulus();
        tick(3);
        checkOutput("t1b_no_drop", 32'(drop_flags), 32'h0);
        checkOutput("t1b_level", 32'(fifo_level), 32'h0);

        // Simultaneous bursts, round-robin order from a fresh pointer
        doReset();
        out_ready = 1'b0;
        setChannel(0, 17'h00A00, 24'h000010);
        setChannel(1, 17'h00B11, 24'h000011);
        setChannel(3, 17'h00D33, 24'h000013);
        applyStimulus();
        tick(3);
        checkOutput("t2_level3", 32'(fifo_level), 32'h3);
        checkOutput("t2_head_ch", 32'(out_channel), 32'h0);
        setChannel(0, 17'h00E00, 24'h000020);
        setChannel(3, 17'h00F33, 24'h000023);
        applyStimulus();
        tick(2);
        checkOutput("t2_level5", 32'(fifo_level), 32'h5);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("t2_order_ch", 32'(out_channel), 32'(exp_ch[i]));
            checkOutput("t2_order_data", 32'(out_data), 32'(exp_dat[i]));
            tick(1);
        end
        checkOutput("t2_drained", 32'(fifo_level), 32'h0);

        // Fill the FIFO, then overrun channel 1's slot
        doReset();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            setChannel(0, 17'(i + 100), 24'(i + 200));
            applyStimulus();
        end
        tick(1);
        checkOutput("t3_full", 32'(fifo_level), 32'd16);
        setChannel(1, 17'h15555, 24'h00AAAA);
        applyStimulus();
        setChannel(1, 17'h16666, 24'h00BBBB);
        setChannel(0, 17'h07777, 24'h00CCCC);
        applyStimulus();
        tick(1);
        checkOutput("t3_drop_flags", 32'(drop_flags), 32'h2);
        checkOutput("t3_drop_count", 32'(drop_count), 32'(EXP_ONE_DROP));
        checkOutput("t3_still_full", 32'(fifo_level), 32'd16);

        // Push and pop together while full keeps the level at 16
        out_ready = 1'b1;
        tick(1);
        checkOutput("t4_full_pp1", 32'(fifo_level), 32'd16);
        tick(1);
        checkOutput("t4_full_pp2", 32'(fifo_level), 32'd16);
        out_ready = 1'b0;
        tick(1);
        checkOutput("t4_hold_full", 32'(fifo_level), 32'd16);
        checkOutput("t4_head_data", 32'(out_data), 32'd102);
        out_ready = 1'b1;
        tick(14);
        checkOutput("t3_held_ch", 32'(out_channel), 32'h1);
        checkOutput("t3_held_data", 32'(out_data), 32'h15555);
        checkOutput("t3_held_ts", 32'(out_timestamp), 32'h00AAAA);
        tick(1);
        checkOutput("t4_last_data", 32'(out_data), 32'h07777);
        tick(1);
        checkOutput("t4_empty", 32'(out_valid), 32'h0);
        checkOutput("t3_flags_sticky", 32'(drop_flags), 32'h2);

        // Async reset mid-burst clears the stream without a clock edge
        out_ready = 1'b0;
        setChannel(2, 17'h01234, 24'h000300);
        setChannel(3, 17'h05678, 24'h000301);
        applyStimulus();
        tick(1);
        checkOutput("t5_pre_level", 32'(fifo_level), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t5_async_valid", 32'(out_valid), 32'h0);
        checkOutput("t5_async_level", 32'(fifo_level), 32'h0);
        checkOutput("t5_async_flags", 32'(drop_flags), 32'h0);
        @(posedge clk_96MHz);
        #1;
        reset = 1'b0;
        tick(3);
        checkOutput("t5_pending_gone", 32'(fifo_level), 32'h0);

        // Timestamp wrap on the 8-bit instance: 255 then 0
        tick(252);
        checkOutput("wrap_ff", 32'(w_ts), 32'hFF);
        tick(1);
        checkOutput("wrap_00", 32'(w_ts), 32'h00);
        checkOutput("ts_256", 32'(system_timestamp), 32'h000100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/multi_receiver_collector.md
Name: multi_receiver_collector

Overview:
- Parametrised successor to the single-receiver top level. Gathers decoded sweep words from NUM_RECV receiver managers and merges them into one ordered stream with channel tags. The stream is buffered in a FIFO with a valid/ready handshake.
- Owns the free-running system timestamp counter that is distributed to every receiver manager.
- Sits between the per-channel single_receiver_manager instances and the downstream packetiser/SPI link.

Parameters:
NUM_RECV, 4, number of receiver channels (1..16)
DATA_W, 17, width of one decoded data word
TS_W, 24, width of system and per-event timestamps
FIFO_DEPTH, 16, output FIFO entries; power of two, >=2
CH_W, derived clog2(NUM_RECV) min 1, channel tag width (localparam)

Ports:
clk_96MHz  in  1  system clock from PLL
reset  in  1  asynchronous, active-high reset
system_timestamp  out  TS_W  free-running counter, fanned out to receivers
chan_valid  in  NUM_RECV  one-cycle data_availible pulse per channel
chan_data  in  NUM_RECV*DATA_W  decoded_data, channel i at [i*DATA_W +: DATA_W]
chan_timestamp  in  NUM_RECV*TS_W  timestamp_last_data, same packing
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_data  out  DATA_W  head data word
out_timestamp  out  TS_W  head timestamp
out_channel  out  CH_W  head source channel
fifo_level  out  clog2(FIFO_DEPTH)+1  current occupancy
drop_flags  out  NUM_RECV  sticky per-channel drop indicator
drop_count  out  8  saturating total dropped events

Behaviour:
- Reset (async assert, sync use after release): system_timestamp=0, all pending slots empty, arbiter pointer=0, FIFO empty, out_valid=0, out_data/out_timestamp/out_channel=0, fifo_level=0, drop_flags=0, drop_count=0.
- system_timestamp increments by 1 each clock and wraps from 2^TS_W-1 to 0. No other effect on wrap.
- Capture stage: each channel has a 1-deep pending slot (data, timestamp, flag). On chan_valid[i], the slot loads on that edge.
  - If the slot is still occupied and is not being granted in the same cycle, the new event is dropped: old content is kept, drop_flags[i] is set, and drop_count increments, saturating at 255.
  - If the slot is being granted in the same cycle, the new event loads and nothing is dropped.
  - Several channels dropping in the same cycle: drop_count increments once per dropped channel, saturating.
- Arbiter: round-robin over pending slots.
  - Search starts at pointer and finds the first pending index at or after the pointer, modulo NUM_RECV.
  - Grant occurs only when the FIFO can accept (level<FIFO_DEPTH, or a pop happens the same cycle).
  - On grant, the pointer becomes granted index+1 mod NUM_RECV. At most one grant per cycle.
- FIFO: first-word-fall-through. Entry = {channel, timestamp, data}.
  - out_valid = level!=0; head fields are valid whenever out_valid=1. Head fields hold their last value when empty.
  - Pop when out_valid & out_ready. Push and pop in the same cycle leaves level unchanged, including when full.
  - out_ready while empty is ignored.
- Latency: chan_valid at edge N -> slot pending after N -> grant/write at edge N+1 -> out_valid=1 after N+1 (2 cycles when uncontended and FIFO not full).
- Backpressure: while the FIFO is full with no pop, slots hold. Drops occur only at slot level; the FIFO never overwrites.
- drop_flags are sticky until reset.
- Reset mid-operation discards all pending and buffered events immediately.

Optional Feature:
DROP_COUNT_EN
- Defined: drop_count behaves as above.
- Undefined: the counter logic is not built and drop_count is tied to 0. drop_flags remain functional.

Test Plan:
- Single event: NUM_RECV=4, chan_valid[2] pulse with data 0x1ABCD and ts 0x000123, out_ready=1 -> out_valid high 2 cycles later with out_channel=2, data 0x1ABCD, ts 0x000123. Popped next cycle, fifo_level returns to 0.
- Simultaneous: pulses on channels 0,1,3 in the same cycle with out_ready=0 -> FIFO order 0,1,3, one per cycle, fifo_level reaches 3. A next simultaneous 0,3 burst starts after 3, giving order 0,3.
- Drop: out_ready=0, fill the FIFO to 16, then 2 pulses on channel 1 -> first event held in slot, second dropped. drop_flags=4'b0010, drop_count=1. After out_ready=1, the held event emerges.
- Full push+pop: level=16, out_ready=1, pending on channel 0 -> level stays 16 and the entry is accepted the same cycle.
- Timestamp wrap: run 2^24 cycles, or preload via force -> 0xFFFFFF followed by 0x000000. Async reset asserted mid-burst clears out_valid and fifo_level with no clock edge.
- Build without DROP_COUNT_EN, repeat the drop test -> drop_count=0 and drop_flags=4'b0010.
